sha256_block_engine: RTL and testbench

//   Parametrised SHA-256/SHA-224 compression engine. It processes one 512-bit padded block per

---
 rtl/sha256_block_engine_if.sv | 22 ++
 rtl/sha256_block_engine.sv | 135 +++++++++++++
 tb/tb_sha256_block_engine.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/sha256_block_engine_if.sv
// rtl/sha256_block_engine_if.sv - block-in / digest-out handshake bundle for sha256_block_engine
interface sha256_block_engine_if;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] in_block;
  logic         in_first;
  logic         in_mode224;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_digest;
  logic         busy;

  modport master (
    output in_valid, in_block, in_first, in_mode224, out_ready,
    input  in_ready, out_valid, out_digest, busy
  );

  modport slave (
    input  in_valid, in_block, in_first, in_mode224, out_ready,
    output in_ready, out_valid, out_digest, busy
  );
endinterface

// File: rtl/sha256_block_engine.sv
// rtl/sha256_block_engine.sv - SHA-256/224 compression engine, RPC rounds per clock, internal chaining
module sha256_block_engine #(
  parameter int RPC       = 2,
  parameter bit EN_SHA224 = 1'b1
) (
  input logic clk,
  input logic reset_n,
  sha256_block_engine_if.slave bus
);

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [31:0] IV256 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [31:0] IV224 [8] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939, 32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  function automatic logic [31:0] big_s0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction
  function automatic logic [31:0] big_s1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction
  function automatic logic [31:0] sml_s0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction
  function automatic logic [31:0] sml_s1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, DONE} state_t;
  state_t       state;
  logic [511:0] blk;
  logic [31:0]  hreg [8];
  logic [31:0]  v    [8];
  logic [31:0]  win  [16];
  logic [6:0]   r;
  logic         mode224;

  logic [31:0]  nv   [8];
  logic [31:0]  nwin [16];
  logic [31:0]  t1, t2, wn;
  logic [255:0] hsum;

  // a..h live in v[0..7]; win[0] is always the word for the round being applied
  always_comb begin
    nv   = v;
    nwin = win;
    t1   = '0;
    t2   = '0;
    wn   = '0;
    for (int i = 0; i < RPC; i++) begin
      t1 = nv[7] + big_s1(nv[4]) + ((nv[4] & nv[5]) ^ (~nv[4] & nv[6])) + K[r[5:0] + 6'(i)] + nwin[0];
      t2 = big_s0(nv[0]) + ((nv[0] & nv[1]) ^ (nv[0] & nv[2]) ^ (nv[1] & nv[2]));
      wn = sml_s1(nwin[14]) + nwin[9] + sml_s0(nwin[1]) + nwin[0];
      nv[7] = nv[6]; nv[6] = nv[5]; nv[5] = nv[4]; nv[4] = nv[3] + t1;
      nv[3] = nv[2]; nv[2] = nv[1]; nv[1] = nv[0]; nv[0] = t1 + t2;
      for (int j = 0; j < 15; j++) nwin[j] = nwin[j+1];
      nwin[15] = wn;
    end
  end

  always_comb begin
    hsum = '0;
    for (int i = 0; i < 8; i++) hsum[255-32*i -: 32] = hreg[i] + v[i];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      bus.in_ready   <= 1'b1;
      bus.out_valid  <= 1'b0;
      bus.out_digest <= '0;
      bus.busy       <= 1'b0;
      mode224        <= 1'b0;
      blk            <= '0;
      r              <= '0;
      for (int i = 0; i < 8; i++) begin
        hreg[i] <= IV256[i];
        v[i]    <= '0;
      end
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          blk <= bus.in_block;
          if (bus.in_first) begin
            mode224 <= bus.in_mode224 & EN_SHA224;
            for (int i = 0; i < 8; i++)
              hreg[i] <= (bus.in_mode224 & EN_SHA224) ? IV224[i] : IV256[i];
          end
          bus.in_ready <= 1'b0;
          bus.busy     <= 1'b1;
          state        <= LOAD;
        end
        LOAD: begin
          for (int j = 0; j < 16; j++) win[j] <= blk[511-32*j -: 32];
          v     <= hreg;
          r     <= '0;
          state <= ROUND;
        end
        ROUND: begin
          v   <= nv;
          win <= nwin;
          r   <= r + 7'(RPC);
          if (r + 7'(RPC) == 7'd64) state <= FINAL;
        end
        FINAL: begin
          for (int i = 0; i < 8; i++) hreg[i] <= hsum[255-32*i -: 32];
          bus.out_digest <= mode224 ? {hsum[255:32], 32'h0} : hsum;
          bus.out_valid  <= 1'b1;
          state          <= DONE;
        end
        DONE: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
          bus.busy      <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_block_engine.sv
// tb/tb_sha256_block_engine.sv - directed known-answer bench for sha256_block_engine (RPC=2 and RPC=1)
module tb_sha256_block_engine;
  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  int   lat;

  localparam logic [255:0] D_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] D_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] D_TWO   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [255:0] D_224   = 256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;

  logic [511:0] b_abc, b_empty, b_two1, b_two2;
  logic [447:0] msg;

  always #5 clk = ~clk;

  sha256_block_engine_if bus1();
  sha256_block_engine_if bus2();

  sha256_block_engine #(.RPC(2), .EN_SHA224(1'b1)) dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2));
  sha256_block_engine #(.RPC(1), .EN_SHA224(1'b1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one block into the selected engine and counts edges from accept to out_valid.
  task automatic run_block(input int sel, input logic [511:0] blk, input logic first,
                           input logic m224, input logic junk, output int cycles);
    @(negedge clk);
    chk("in_ready_before_send", sel == 1 ? bus1.in_ready : bus2.in_ready, 1);
    if (sel == 1) begin
      bus1.in_block = blk; bus1.in_first = first; bus1.in_mode224 = m224; bus1.in_valid = 1'b1;
    end else begin
      bus2.in_block = blk; bus2.in_first = first; bus2.in_mode224 = m224; bus2.in_valid = 1'b1;
    end
    @(posedge clk); #1;
    chk("busy_after_accept", sel == 1 ? bus1.busy : bus2.busy, 1);
    if (junk) begin
      bus2.in_block = ~blk; bus2.in_first = 1'b1; bus2.in_mode224 = 1'b1;
    end else begin
      bus1.in_valid = 1'b0; bus2.in_valid = 1'b0;
    end
    cycles = 0;
    while (!(sel == 1 ? bus1.out_valid : bus2.out_valid) && cycles < 300) begin
      @(posedge clk); #1;
      cycles++;
      if (cycles == 5) bus2.in_valid = 1'b0;
    end
  endtask

  task automatic take_out(input int sel);
    @(negedge clk);
    if (sel == 1) bus1.out_ready = 1'b1; else bus2.out_ready = 1'b1;
    @(posedge clk); #1;
    bus1.out_ready = 1'b0; bus2.out_ready = 1'b0;
  endtask

  initial begin
    msg     = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    b_abc   = {32'h61626380, 416'h0, 64'h18};
    b_empty = {32'h80000000, 480'h0};
    b_two1  = {msg, 32'h80000000, 32'h0};
    b_two2  = {448'h0, 64'd448};
    reset_n = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_block = '0; bus1.in_first = 1'b0; bus1.in_mode224 = 1'b0; bus1.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_block = '0; bus2.in_first = 1'b0; bus2.in_mode224 = 1'b0; bus2.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", bus2.in_ready, 1);
    chk("reset_out_valid", bus2.out_valid, 0);
    chk("reset_out_digest", bus2.out_digest, 0);
    chk("reset_busy", bus2.busy, 0);
    @(negedge clk) reset_n = 1'b1;

    // RPC=1, in_first=0 straight after reset chains from the SHA-256 IV
    run_block(1, b_abc, 1'b0, 1'b0, 1'b0, lat);
    chk("latency_rpc1", lat, 66);
    chk("abc_rpc1_chain_from_reset", bus1.out_digest, D_ABC);
    take_out(1);

    run_block(2, b_abc, 1'b1, 1'b0, 1'b0, lat);
    chk("latency_rpc2", lat, 34);
    chk("abc_digest", bus2.out_digest, D_ABC);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold_out_valid", bus2.out_valid, 1);
      chk("hold_out_digest", bus2.out_digest, D_ABC);
      chk("hold_in_ready", bus2.in_ready, 0);
    end
    take_out(2);
    chk("release_out_valid", bus2.out_valid, 0);
    chk("release_in_ready", bus2.in_ready, 1);
    chk("release_busy", bus2.busy, 0);

    run_block(2, b_empty, 1'b1, 1'b0, 1'b0, lat);
    chk("empty_digest", bus2.out_digest, D_EMPTY);
    take_out(2);

    run_block(2, b_two1, 1'b1, 1'b0, 1'b0, lat);
    take_out(2);
    run_block(2, b_two2, 1'b0, 1'b0, 1'b0, lat);
    chk("two_block_digest", bus2.out_digest, D_TWO);
    take_out(2);

    run_block(2, b_abc, 1'b1, 1'b1, 1'b0, lat);
    chk("sha224_abc_digest", bus2.out_digest, D_224);
    take_out(2);

    // abort at r=20: accept edge, LOAD edge, then 10 ROUND edges
    @(negedge clk);
    bus2.in_block = b_empty; bus2.in_first = 1'b1; bus2.in_mode224 = 1'b0; bus2.in_valid = 1'b1;
    @(posedge clk); #1;
    bus2.in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("abort_out_valid", bus2.out_valid, 0);
    chk("abort_out_digest", bus2.out_digest, 0);
    chk("abort_in_ready", bus2.in_ready, 1);
    chk("abort_busy", bus2.busy, 0);
    @(negedge clk) reset_n = 1'b1;

    // in_valid held with a different block while busy must not disturb the hash
    run_block(2, b_abc, 1'b1, 1'b0, 1'b1, lat);
    chk("abc_after_abort_latency", lat, 34);
    chk("abc_after_abort_digest", bus2.out_digest, D_ABC);
    take_out(2);
    chk("final_in_ready", bus2.in_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
